// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI mode-0 receive path.
//   spi_rx_state_t : receiver FSM states
//   BYTE_W         : bits per SPI byte
//   BIT_CNT_W      : width of the bit-within-byte counter
//   BYTE_CNT_W     : width of the byte-within-word counter (fixed at 2 to match the master framing)
//   SPI_CPOL/CPHA  : the link runs in mode 0 (sclk idles low, sample on rise, shift on fall)
package spi_pkg;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        ACTIVE    = 2'd2
    } spi_rx_state_t;

    localparam int   BYTE_W     = 8;
    localparam int   BIT_CNT_W  = 3;
    localparam int   BYTE_CNT_W = 2;
    localparam logic SPI_CPOL   = 1'b0;
    localparam logic SPI_CPHA   = 1'b0;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous SPI pin plus rise/fall detection
// on the synchronized value. The edge strobes are combinational from flops and
// are high for exactly the one clk cycle after the synchronized value changes.
//   clk   : system clock
//   rst   : asynchronous active-low reset
//   din   : asynchronous pin
//   dout  : synchronized pin value
//   rise  : synchronized 0->1 strobe
//   fall  : synchronized 1->0 strobe
// RESET_VAL sets the idle level the chain (and its delayed copy) resets to,
// so no spurious edge is reported out of reset.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   dly_q;
    logic                   dly_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        dly_d  = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            dly_q  <= RESET_VAL;
        end else begin
            sync_q <= sync_d;
            dly_q  <= dly_d;
        end
    end

    assign dout = sync_q[SYNC_STAGES-1];
    assign rise = dout & ~dly_q;
    assign fall = ~dout & dly_q;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 responder. Oversamples sclk/cs_n/mosi in the clk domain,
// assembles MSB-first bytes into a DATA_BYTES-wide word (byte 0 in the MSBs)
// and shifts a preloaded response word out on miso in the same frame.
//   clk           : system clock, >= 4x sclk
//   rst           : asynchronous active-low reset
//   sclk, cs_n    : SPI clock / chip select from the master (async)
//   mosi          : master-out data (async)
//   miso          : slave-out data, 0 outside a frame
//   tx_word       : response word, taken at frame start and at each word boundary
//   rx_byte       : last completed byte, with rx_byte_valid pulse and byte_idx slot
//   rx_word       : last completed word, with rx_word_valid pulse
//   frame_err     : pulse when cs_n rises mid-byte or mid-word
//   busy          : high while a frame is being received
//
// state     | meaning
// ----------+-------------------------------------------------------------
// WAIT_IDLE | after reset; wait for synchronizers to settle and cs_n high
// IDLE      | no frame; waiting for cs_n to fall
// ACTIVE    | inside a frame; shifting on sclk edges
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int DATA_BYTES  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sclk,
    input  logic                         cs_n,
    input  logic                         mosi,
    output logic                         miso,
    input  logic [BYTE_W*DATA_BYTES-1:0] tx_word,
    output logic [BYTE_W-1:0]            rx_byte,
    output logic                         rx_byte_valid,
    output logic [BYTE_CNT_W-1:0]        byte_idx,
    output logic [BYTE_W*DATA_BYTES-1:0] rx_word,
    output logic                         rx_word_valid,
    output logic                         frame_err,
    output logic                         busy
);

    localparam int W        = BYTE_W * DATA_BYTES;
    localparam int SETTLE_W = $clog2(SYNC_STAGES + 1);
    localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(DATA_BYTES - 1);
    localparam logic [BIT_CNT_W-1:0]  LAST_BIT  = BIT_CNT_W'(BYTE_W - 1);

    // ------------------------------------------------------------------
    // Input synchronization
    // ------------------------------------------------------------------
    logic sclk_s, sclk_rise, sclk_fall;
    logic cs_n_s, cs_n_rise, cs_n_fall;
    logic mosi_s;

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (SPI_CPOL)
    ) u_sync_sclk (
        .clk  (clk),
        .rst  (rst),
        .din  (sclk),
        .dout (sclk_s),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_sync_cs_n (
        .clk  (clk),
        .rst  (rst),
        .din  (cs_n),
        .dout (cs_n_s),
        .rise (cs_n_rise),
        .fall (cs_n_fall)
    );

    // mosi only needs a level, sampled on sclk rise; same depth as sclk keeps
    // the data aligned with the edge that qualifies it.
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_d;

    always_comb begin
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    end

    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // sclk level itself is not needed; only its edges are.
    logic sclk_level_unused;
    assign sclk_level_unused = sclk_s;

    // ------------------------------------------------------------------
    // Receiver state
    // ------------------------------------------------------------------
    spi_rx_state_t           state_q, state_d;
    logic [SETTLE_W-1:0]     settle_cnt_q, settle_cnt_d;
    logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [BYTE_CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [BYTE_W-1:0]       rx_shift_q, rx_shift_d;
    logic [W-1:0]            tx_shift_q, tx_shift_d;
    logic                    reload_q, reload_d;
    logic [W-1:0]            acc_q, acc_d;

    logic [BYTE_W-1:0]       rx_byte_q, rx_byte_d;
    logic                    rx_byte_valid_q, rx_byte_valid_d;
    logic [BYTE_CNT_W-1:0]   byte_idx_q, byte_idx_d;
    logic [W-1:0]            rx_word_q, rx_word_d;
    logic                    rx_word_valid_q, rx_word_valid_d;
    logic                    frame_err_q, frame_err_d;
    logic                    busy_q, busy_d;
    logic                    miso_q, miso_d;

    logic [BYTE_W-1:0]       new_byte;
    logic [W-1:0]            word_next;

    always_comb begin
        state_d         = state_q;
        settle_cnt_d    = settle_cnt_q;
        bit_cnt_d       = bit_cnt_q;
        byte_cnt_d      = byte_cnt_q;
        rx_shift_d      = rx_shift_q;
        tx_shift_d      = tx_shift_q;
        reload_d        = reload_q;
        acc_d           = acc_q;
        rx_byte_d       = rx_byte_q;
        rx_byte_valid_d = 1'b0;
        byte_idx_d      = byte_idx_q;
        rx_word_d       = rx_word_q;
        rx_word_valid_d = 1'b0;
        frame_err_d     = 1'b0;

        new_byte  = {rx_shift_q[BYTE_W-2:0], mosi_s};

        // Accumulator with the byte being completed dropped into its slot.
        word_next = acc_q;
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (byte_cnt_q == BYTE_CNT_W'(i)) begin
                word_next[W-1-BYTE_W*i -: BYTE_W] = new_byte;
            end
        end

        unique case (state_q)
            WAIT_IDLE: begin
                // The cs_n synchronizer resets to 1; until it has been refilled
                // from the pin, a high value there says nothing about the bus.
                if (settle_cnt_q != SETTLE_W'(SYNC_STAGES)) begin
                    settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
                end else if (cs_n_s) begin
                    state_d = IDLE;
                end
            end

            IDLE: begin
                if (cs_n_fall) begin
                    state_d    = ACTIVE;
                    bit_cnt_d  = '0;
                    byte_cnt_d = '0;
                    rx_shift_d = '0;
                    acc_d      = '0;
                    reload_d   = 1'b0;
                    tx_shift_d = tx_word;
                end
            end

            ACTIVE: begin
                if (cs_n_rise) begin
                    state_d = IDLE;
                    if ((bit_cnt_q != '0) || (byte_cnt_q != '0)) begin
                        frame_err_d = 1'b1;
                    end
                end else if (sclk_rise) begin
                    rx_shift_d = new_byte;
                    bit_cnt_d  = bit_cnt_q + BIT_CNT_W'(1);
                    if (bit_cnt_q == LAST_BIT) begin
                        rx_byte_d       = new_byte;
                        rx_byte_valid_d = 1'b1;
                        byte_idx_d      = byte_cnt_q;
                        acc_d           = word_next;
                        if (byte_cnt_q == LAST_BYTE) begin
                            rx_word_d       = word_next;
                            rx_word_valid_d = 1'b1;
                            byte_cnt_d      = '0;
                            reload_d        = 1'b1;
                        end else begin
                            byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
                        end
                    end
                end else if (sclk_fall) begin
                    // At a word boundary the next fall presents the new
                    // response word's MSB instead of shifting.
                    if (reload_q) begin
                        tx_shift_d = tx_word;
                        reload_d   = 1'b0;
                    end else begin
                        tx_shift_d = tx_shift_q << 1;
                    end
                end
            end

            default: begin
                state_d = WAIT_IDLE;
            end
        endcase

        busy_d = (state_d == ACTIVE);
        miso_d = (state_d == ACTIVE) ? tx_shift_d[W-1] : 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mosi_sync_q     <= '0;
            state_q         <= WAIT_IDLE;
            settle_cnt_q    <= '0;
            bit_cnt_q       <= '0;
            byte_cnt_q      <= '0;
            rx_shift_q      <= '0;
            tx_shift_q      <= '0;
            reload_q        <= 1'b0;
            acc_q           <= '0;
            rx_byte_q       <= '0;
            rx_byte_valid_q <= 1'b0;
            byte_idx_q      <= '0;
            rx_word_q       <= '0;
            rx_word_valid_q <= 1'b0;
            frame_err_q     <= 1'b0;
            busy_q          <= 1'b0;
            miso_q          <= 1'b0;
        end else begin
            mosi_sync_q     <= mosi_sync_d;
            state_q         <= state_d;
            settle_cnt_q    <= settle_cnt_d;
            bit_cnt_q       <= bit_cnt_d;
            byte_cnt_q      <= byte_cnt_d;
            rx_shift_q      <= rx_shift_d;
            tx_shift_q      <= tx_shift_d;
            reload_q        <= reload_d;
            acc_q           <= acc_d;
            rx_byte_q       <= rx_byte_d;
            rx_byte_valid_q <= rx_byte_valid_d;
            byte_idx_q      <= byte_idx_d;
            rx_word_q       <= rx_word_d;
            rx_word_valid_q <= rx_word_valid_d;
            frame_err_q     <= frame_err_d;
            busy_q          <= busy_d;
            miso_q          <= miso_d;
        end
    end

    assign miso          = miso_q;
    assign rx_byte       = rx_byte_q;
    assign rx_byte_valid = rx_byte_valid_q;
    assign byte_idx      = byte_idx_q;
    assign rx_word       = rx_word_q;
    assign rx_word_valid = rx_word_valid_q;
    assign frame_err     = frame_err_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
`timescale 1ns/1ps
module tb_spi_slave_rx;

    localparam int  DB    = 4;
    localparam int  SS    = 2;
    localparam int  HALF  = 4;              // sclk half-period in clk cycles (clk/8)
    localparam time CLK_T = 10;
    localparam time LAT   = (SS + 1) * CLK_T; // pin rise at negedge -> valid seen at negedge

    logic        clk = 1'b0;
    logic        rst;
    logic        sclk, cs_n, mosi, miso;
    logic [31:0] tx_word;
    logic [7:0]  rx_byte;
    logic        rx_byte_valid;
    logic [1:0]  byte_idx;
    logic [31:0] rx_word;
    logic        rx_word_valid, frame_err, busy;

    always #5 clk = ~clk;

    spi_slave_rx #(.DATA_BYTES(DB), .SYNC_STAGES(SS)) dut (
        .clk           (clk),
        .rst           (rst),
        .sclk          (sclk),
        .cs_n          (cs_n),
        .mosi          (mosi),
        .miso          (miso),
        .tx_word       (tx_word),
        .rx_byte       (rx_byte),
        .rx_byte_valid (rx_byte_valid),
        .byte_idx      (byte_idx),
        .rx_word       (rx_word),
        .rx_word_valid (rx_word_valid),
        .frame_err     (frame_err),
        .busy          (busy)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [9:0]  exp_byte_q[$];   // {byte_idx, byte}
    logic [31:0] exp_word_q[$];
    int          exp_err = 0;
    time         t_rise8 = 0;
    logic [7:0]  mo_buf[0:15];
    logic [7:0]  mi_buf[0:15];
    logic [31:0] tx_buf[0:3];

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Master side: drives nbits MSB-first, samples miso just before each rise.
    task automatic xfer_byte(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = 8'h00;
        for (int b = 0; b < nbits; b++) begin
            mosi = mo[7-b];
            repeat (HALF) @(negedge clk);
            mi = {mi[6:0], miso};
            sclk = 1'b1;
            if (b == 7) t_rise8 = $time;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    // One cs_n frame: nbytes full bytes then extra_bits of an unfinished byte.
    task automatic run_frame(input int nbytes, input int extra_bits);
        logic [31:0] acc;
        logic [31:0] cur_tx;
        logic [7:0]  mi;
        int          slot;
        acc = 32'h0;
        tx_word = tx_buf[0];
        cs_n = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("busy_in_frame", busy, 1'b1);
        for (int k = 0; k < nbytes; k++) begin
            slot = k % DB;
            if (slot == DB - 1) tx_word = tx_buf[k/DB + 1];
            exp_byte_q.push_back({2'(slot), mo_buf[k]});
            acc[8*(DB-1-slot) +: 8] = mo_buf[k];
            if (slot == DB - 1) exp_word_q.push_back(acc);
            xfer_byte(mo_buf[k], 8, mi);
            mi_buf[k] = mi;
            cur_tx = tx_buf[k/DB];
            check_eq("miso_byte", mi, cur_tx[8*(DB-1-slot) +: 8]);
        end
        if (extra_bits != 0) xfer_byte(8'($urandom), extra_bits, mi);
        repeat (2) @(negedge clk);
        if (extra_bits != 0 || (nbytes % DB) != 0) exp_err++;
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
        check_eq("busy_after_frame", busy, 1'b0);
        check_eq("frame_err_seen", exp_err, 0);
        check_eq("bytes_drained", exp_byte_q.size() + exp_word_q.size(), 0);
    endtask

    // Compare process: every negedge, outputs vs. the transaction-level model.
    logic [7:0]  prev_byte;
    logic [1:0]  prev_idx;
    logic [31:0] prev_word;
    initial begin : compare
        logic [9:0] e;
        prev_byte = 0; prev_idx = 0; prev_word = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check_eq("reset_outputs",
                         {rx_byte, byte_idx, rx_word, rx_byte_valid, rx_word_valid, frame_err, busy, miso},
                         0);
                prev_byte = 0; prev_idx = 0; prev_word = 0;
            end else begin
                if (rx_byte_valid) begin
                    check_eq("byte_expected", exp_byte_q.size() != 0, 1'b1);
                    if (exp_byte_q.size() != 0) begin
                        e = exp_byte_q.pop_front();
                        check_eq("rx_byte", rx_byte, e[7:0]);
                        check_eq("byte_idx", byte_idx, e[9:8]);
                        check_eq("byte_latency", $time - t_rise8, LAT);
                    end
                    prev_byte = rx_byte; prev_idx = byte_idx;
                end else begin
                    check_eq("byte_hold", {rx_byte, byte_idx}, {prev_byte, prev_idx});
                end
                if (rx_word_valid) begin
                    check_eq("word_with_last_byte", {rx_byte_valid, byte_idx}, {1'b1, 2'(DB-1)});
                    check_eq("word_expected", exp_word_q.size() != 0, 1'b1);
                    if (exp_word_q.size() != 0) check_eq("rx_word", rx_word, exp_word_q.pop_front());
                    prev_word = rx_word;
                end else begin
                    check_eq("word_hold", rx_word, prev_word);
                end
                if (frame_err) begin
                    check_eq("err_expected", exp_err > 0, 1'b1);
                    if (exp_err > 0) exp_err--;
                end
                if (!busy) check_eq("miso_idle", miso, 1'b0);
            end
        end
    end

    initial begin : main
        logic [7:0] mi;
        rst = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; tx_word = 32'h0;
        repeat (3) @(negedge clk);
        check_eq("reset_busy", busy, 1'b0);
        check_eq("reset_rx_word", rx_word, 32'h0);
        #2 rst = 1'b1;
        repeat (6) @(negedge clk);

        // Directed single word
        tx_buf[0] = 32'h12345678; tx_buf[1] = 32'h0;
        mo_buf[0] = 8'hA5; mo_buf[1] = 8'h3C; mo_buf[2] = 8'h0F; mo_buf[3] = 8'hF0;
        run_frame(4, 0);
        check_eq("lit_rx_word", rx_word, 32'hA53C0FF0);
        check_eq("lit_miso", {mi_buf[0], mi_buf[1], mi_buf[2], mi_buf[3]}, 32'h12345678);
        check_eq("lit_byte_idx", byte_idx, 2'd3);

        // Abort after 5 bits of byte 1
        mo_buf[0] = 8'h5A;
        run_frame(1, 5);
        check_eq("lit_abort_word", rx_word, 32'hA53C0FF0);
        check_eq("lit_abort_byte", {rx_byte, byte_idx}, {8'h5A, 2'd0});
        check_eq("lit_abort_busy", busy, 1'b0);

        // Two words under one cs_n, response word changes at the boundary
        tx_buf[0] = 32'h0BADF00D; tx_buf[1] = 32'hCAFEBABE; tx_buf[2] = 32'h0;
        for (int i = 0; i < 8; i++) mo_buf[i] = 8'(8'h11 * (i + 1));
        run_frame(8, 0);
        check_eq("lit_miso_b4", mi_buf[4], 8'hCA);
        check_eq("lit_miso_b7", mi_buf[7], 8'hBE);
        check_eq("lit_word2", rx_word, 32'h55667788);

        // Reset during byte 2, release with cs_n still low
        tx_word = 32'($urandom);
        cs_n = 1'b0;
        repeat (6) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            mo_buf[k] = 8'($urandom);
            exp_byte_q.push_back({2'(k), mo_buf[k]});
            xfer_byte(mo_buf[k], 8, mi);
        end
        xfer_byte(8'($urandom), 3, mi);
        @(negedge clk); #2 rst = 1'b0;
        repeat (3) @(negedge clk); #2 rst = 1'b1;
        xfer_byte(8'($urandom), 5, mi);
        xfer_byte(8'($urandom), 8, mi);
        xfer_byte(8'($urandom), 8, mi);
        check_eq("rst_no_join_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        cs_n = 1'b1;
        repeat (10) @(negedge clk);
        check_eq("rst_no_err", exp_err, 0);
        for (int i = 0; i < 4; i++) mo_buf[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) tx_buf[i] = 32'($urandom);
        run_frame(4, 0);
        check_eq("rst_next_frame", rx_word, {mo_buf[0], mo_buf[1], mo_buf[2], mo_buf[3]});

        // sclk/mosi activity with cs_n high must change nothing
        for (int i = 0; i < 30; i++) begin
            sclk = ~sclk;
            mosi = 1'($urandom);
            repeat ($urandom_range(1, 5)) @(negedge clk);
        end
        sclk = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("idle_word", rx_word, {mo_buf[0], mo_buf[1], mo_buf[2], mo_buf[3]});
        check_eq("idle_busy", busy, 1'b0);

        // Randomized frames, including partial words and partial bytes
        for (int f = 0; f < 12; f++) begin
            int nb;
            int eb;
            nb = $urandom_range(0, 9);
            eb = $urandom_range(0, 7);
            for (int i = 0; i < 16; i++) mo_buf[i] = 8'($urandom);
            for (int i = 0; i < 4; i++) tx_buf[i] = 32'($urandom);
            run_frame(nb, eb);
        end

        check_eq("final_queues", exp_byte_q.size() + exp_word_q.size() + exp_err, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
